demux4a1_capture: RTL and testbench

DEMUX4A1_CAPTURE -- requirements
Module: demux4a1_capture

---
 rtl/demux4a1_capture_pkg.sv | 26 ++
 rtl/demux4a1_capture_dec2a4.sv | 33 +++
 rtl/demux4a1_capture.sv | 148 ++++++++++++++
 tb/tb_demux4a1_capture.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/demux4a1_capture_pkg.sv
// ---------------------------------------------------------------------------
// demux4a1_capture_pkg
// Shared definitions for the 4-slot BCD capture demultiplexer and the matching
// 4:1 display multiplexer: slot count, slot index width and FSM encodings.
// ---------------------------------------------------------------------------
package demux4a1_capture_pkg;

    // Number of time-multiplexed slots per frame (one per BCD digit).
    localparam int unsigned SLOT_COUNT = 4;

    // Width of a slot index.
    localparam int unsigned SEL_W = 2;

    // Index of the last slot of a frame.
    localparam logic [SEL_W-1:0] LAST_SEL = 2'd3;

    // Capture FSM encodings, 1 bit.
    localparam logic ST_IDLE_ENC = 1'b0;
    localparam logic ST_RECV_ENC = 1'b1;

    typedef enum logic {
        ST_IDLE = ST_IDLE_ENC,  // waiting for a start of frame
        ST_RECV = ST_RECV_ENC   // collecting slots 1..3
    } state_e;

endpackage : demux4a1_capture_pkg

// File: rtl/demux4a1_capture_dec2a4.sv
// ---------------------------------------------------------------------------
// dec2a4
// 2-to-4 one-hot decoder with enable. Turns a slot index into per-slot write
// enables.
//   code   : slot index (0..3)
//   en     : decoder enable; all outputs low when 0
//   onehot : one-hot write enables, bit i set when en=1 and code=i
// ---------------------------------------------------------------------------
module dec2a4
    import demux4a1_capture_pkg::*;
(
    input  logic [SEL_W-1:0] code,
    input  logic             en,
    output logic [3:0]       onehot
);

    // One-hot decode of the slot index, gated by the enable.
    always_comb begin
        onehot = 4'b0000;
        if (en) begin
            case (code)
                2'd0:    onehot = 4'b0001;
                2'd1:    onehot = 4'b0010;
                2'd2:    onehot = 4'b0100;
                2'd3:    onehot = 4'b1000;
                default: onehot = 4'b0000;
            endcase
        end else begin
            onehot = 4'b0000;
        end
    end

endmodule : dec2a4

// File: rtl/demux4a1_capture.sv
// ---------------------------------------------------------------------------
// demux4a1_capture
// Captures a time-multiplexed stream of four WIDTH-bit words (a frame, slot 0
// marked by sof) into four registered parallel outputs. Slots 0..2 are held in
// a shadow buffer; the outputs update atomically when slot 3 arrives, so a
// partial frame never becomes visible.
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   din        : time-multiplexed data word
//   din_valid  : din is meaningful this cycle
//   sof        : start of frame (qualified by din_valid), din is slot 0
//   q0..q3     : last complete frame
//   sel        : index of the next slot to be captured
//   frame_done : one-cycle pulse, q0..q3 were just updated
//   sync_err   : one-cycle pulse, frame restarted by an early sof
// ---------------------------------------------------------------------------
module demux4a1_capture
    import demux4a1_capture_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             sof,
    output logic [WIDTH-1:0] q0,
    output logic [WIDTH-1:0] q1,
    output logic [WIDTH-1:0] q2,
    output logic [WIDTH-1:0] q3,
    output logic [SEL_W-1:0] sel,
    output logic             frame_done,
    output logic             sync_err
);

    state_e           state_r;
    logic [SEL_W-1:0] sel_r;
    logic [WIDTH-1:0] shadow_r [0:SLOT_COUNT-2];
    logic [WIDTH-1:0] q0_r;
    logic [WIDTH-1:0] q1_r;
    logic [WIDTH-1:0] q2_r;
    logic [WIDTH-1:0] q3_r;
    logic             frame_done_r;
    logic             sync_err_r;

    logic [SEL_W-1:0] dec_code_s;
    logic             dec_en_s;
    logic [3:0]       we_s;

    // Decoder input: a valid sof always targets slot 0 (in either state);
    // otherwise only RECV accepts words, at the current slot index.
    always_comb begin
        dec_code_s = sel_r;
        dec_en_s   = 1'b0;
        if (din_valid && sof) begin
            dec_code_s = 2'd0;
            dec_en_s   = 1'b1;
        end else if (din_valid && (state_r == ST_RECV)) begin
            dec_code_s = sel_r;
            dec_en_s   = 1'b1;
        end else begin
            dec_code_s = sel_r;
            dec_en_s   = 1'b0;
        end
    end

    // we_s[0..2] write the shadow slots; we_s[3] marks the frame-completing word.
    dec2a4 u_dec2a4 (
        .code   (dec_code_s),
        .en     (dec_en_s),
        .onehot (we_s)
    );

    // Capture FSM: state, slot index, shadow buffer, outputs and pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            sel_r        <= 2'd0;
            q0_r         <= '0;
            q1_r         <= '0;
            q2_r         <= '0;
            q3_r         <= '0;
            frame_done_r <= 1'b0;
            sync_err_r   <= 1'b0;
            for (int i = 0; i < SLOT_COUNT - 1; i++) begin
                shadow_r[i] <= '0;
            end
        end else begin
            // Pulses default low so each lasts exactly one cycle.
            frame_done_r <= 1'b0;
            sync_err_r   <= 1'b0;

            if (we_s[0]) shadow_r[0] <= din;
            if (we_s[1]) shadow_r[1] <= din;
            if (we_s[2]) shadow_r[2] <= din;

            if (din_valid) begin
                case (state_r)
                    ST_IDLE: begin
                        // Words outside a frame are dropped silently.
                        if (sof) begin
                            sel_r   <= 2'd1;
                            state_r <= ST_RECV;
                        end
                    end
                    ST_RECV: begin
                        if (sof) begin
                            // Early sof: restart the frame, outputs untouched.
                            sync_err_r <= 1'b1;
                            sel_r      <= 2'd1;
                        end else if (we_s[3]) begin
                            // Slot 3 goes straight to q3 so the whole frame
                            // lands on the same edge.
                            q0_r         <= shadow_r[0];
                            q1_r         <= shadow_r[1];
                            q2_r         <= shadow_r[2];
                            q3_r         <= din;
                            frame_done_r <= 1'b1;
                            sel_r        <= 2'd0;
                            state_r      <= ST_IDLE;
                        end else begin
                            sel_r <= sel_r + 2'd1;
                        end
                    end
                    default: begin
                        sel_r   <= 2'd0;
                        state_r <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign q0         = q0_r;
    assign q1         = q1_r;
    assign q2         = q2_r;
    assign q3         = q3_r;
    assign sel        = sel_r;
    assign frame_done = frame_done_r;
    assign sync_err   = sync_err_r;

    // LAST_SEL documents the completing slot for the display multiplexer side.
    logic last_slot_s;
    assign last_slot_s = (sel_r == LAST_SEL);
    logic unused_s;
    assign unused_s = last_slot_s;

endmodule : demux4a1_capture

// File: tb/tb_demux4a1_capture.sv
// ---------------------------------------------------------------------------
// tb_demux4a1_capture
// Self-checking bench: a table of per-cycle {inputs, expected outputs}
// vectors, expectations pushed to a scoreboard queue when driven and popped
// when the outputs are sampled, plus hand sequences for asynchronous reset.
// ---------------------------------------------------------------------------
module tb_demux4a1_capture;

    logic       clk;
    logic       rst;
    logic [3:0] din;
    logic       din_valid;
    logic       sof;
    logic [3:0] q0, q1, q2, q3;
    logic [1:0] sel;
    logic       frame_done;
    logic       sync_err;

    int n_vec;
    int n_bad;

    typedef struct {
        logic        rst;
        logic        valid;
        logic        sof;
        logic [3:0]  din;
        logic [15:0] eq;     // expected {q0,q1,q2,q3}
        logic [1:0]  esel;
        logic        edone;
        logic        eerr;
    } vec_t;

    vec_t        vecs[$];
    logic [19:0] sb_q[$];
    logic [19:0] obs;

    assign obs = {q0, q1, q2, q3, sel, frame_done, sync_err};

    demux4a1_capture #(.WIDTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .sof        (sof),
        .q0         (q0),
        .q1         (q1),
        .q2         (q2),
        .q3         (q3),
        .sel        (sel),
        .frame_done (frame_done),
        .sync_err   (sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    function automatic vec_t mk(input logic r, input logic v, input logic s,
                                input logic [3:0] d, input logic [15:0] eq,
                                input logic [1:0] esel, input logic edone,
                                input logic eerr);
        vec_t t;
        t.rst = r; t.valid = v; t.sof = s; t.din = d;
        t.eq = eq; t.esel = esel; t.edone = edone; t.eerr = eerr;
        return t;
    endfunction

    task automatic check_obs(input string name, input logic [19:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got q=%h sel=%0d done=%b err=%b, expected q=%h sel=%0d done=%b err=%b",
                     name, obs[19:4], obs[3:2], obs[1], obs[0],
                     exp[19:4], exp[3:2], exp[1], exp[0]);
        end
    endtask

    // Drive one vector at the falling edge, sample just after the rising edge.
    task automatic apply(input vec_t v, input string name);
        logic [19:0] exp;
        @(negedge clk);
        rst       = v.rst;
        din_valid = v.valid;
        sof       = v.sof;
        din       = v.din;
        sb_q.push_back({v.eq, v.esel, v.edone, v.eerr});
        @(posedge clk);
        #1;
        exp = sb_q.pop_front();
        check_obs(name, exp);
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst = 1'b1; din = 4'h0; din_valid = 1'b0; sof = 1'b0;

        // reset state
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 4'h0, 16'h0000, 2'd0, 1'b0, 1'b0));
        // basic frame 3,7,1,9
        vecs.push_back(mk(1'b0, 1'b1, 1'b1, 4'h3, 16'h0000, 2'd1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 4'h7, 16'h0000, 2'd2, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 4'h1, 16'h0000, 2'd3, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 4'h9, 16'h3719, 2'd0, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 4'h0, 16'h3719, 2'd0, 1'b0, 1'b0));
        // words in IDLE are dropped
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 4'hF, 16'h3719, 2'd0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 4'hA, 16'h3719, 2'd0, 1'b0, 1'b0));
        // same frame with 2-cycle gaps
        vecs.push_back(mk(1'b0, 1'b1, 1'b1, 4'h3, 16'h3719, 2'd1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 4'h5, 16'h3719, 2'd1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 4'h5, 16'h3719, 2'd1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 4'h7, 16'h3719, 2'd2, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 4'h0, 16'h3719, 2'd2, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 4'h0, 16'h3719, 2'd2, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 4'h1, 16'h3719, 2'd3, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 4'h0, 16'h3719, 2'd3, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 4'h0, 16'h3719, 2'd3, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 4'h9, 16'h3719, 2'd0, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 4'h0, 16'h3719, 2'd0, 1'b0, 1'b0));
        // early sof: 2,4 discarded, frame 5,6,8,0
        vecs.push_back(mk(1'b0, 1'b1, 1'b1, 4'h2, 16'h3719, 2'd1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 4'h4, 16'h3719, 2'd2, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b1, 4'h5, 16'h3719, 2'd1, 1'b0, 1'b1));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 4'h6, 16'h3719, 2'd2, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 4'h8, 16'h3719, 2'd3, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 4'h0, 16'h5680, 2'd0, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 4'h0, 16'h5680, 2'd0, 1'b0, 1'b0));
        // back-to-back frames A,B,C,D then 1,2,3,4
        vecs.push_back(mk(1'b0, 1'b1, 1'b1, 4'hA, 16'h5680, 2'd1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 4'hB, 16'h5680, 2'd2, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 4'hC, 16'h5680, 2'd3, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 4'hD, 16'hABCD, 2'd0, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b1, 4'h1, 16'hABCD, 2'd1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 4'h2, 16'hABCD, 2'd2, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 4'h3, 16'hABCD, 2'd3, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 4'h4, 16'h1234, 2'd0, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 4'h0, 16'h1234, 2'd0, 1'b0, 1'b0));
        // sof without din_valid is ignored
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 4'hF, 16'h1234, 2'd0, 1'b0, 1'b0));
        // early sof at the last slot
        vecs.push_back(mk(1'b0, 1'b1, 1'b1, 4'h1, 16'h1234, 2'd1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 4'h2, 16'h1234, 2'd2, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 4'h3, 16'h1234, 2'd3, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b1, 4'h7, 16'h1234, 2'd1, 1'b0, 1'b1));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 4'h8, 16'h1234, 2'd2, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 4'h9, 16'h1234, 2'd3, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 4'h5, 16'h7895, 2'd0, 1'b1, 1'b0));

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end

        // Frame 3,7,1,9; reset asserted while frame_done is high.
        apply(mk(1'b0, 1'b1, 1'b1, 4'h3, 16'h7895, 2'd1, 1'b0, 1'b0), "rstA_w0");
        apply(mk(1'b0, 1'b1, 1'b0, 4'h7, 16'h7895, 2'd2, 1'b0, 1'b0), "rstA_w1");
        apply(mk(1'b0, 1'b1, 1'b0, 4'h1, 16'h7895, 2'd3, 1'b0, 1'b0), "rstA_w2");
        apply(mk(1'b0, 1'b1, 1'b0, 4'h9, 16'h3719, 2'd0, 1'b1, 1'b0), "rstA_w3");
        #2 rst = 1'b1;
        #1 check_obs("async_rst_pulse", 20'h00000);

        // Frame 3,7,1,9, partial (1,2),(0,2), then asynchronous reset.
        apply(mk(1'b0, 1'b1, 1'b1, 4'h3, 16'h0000, 2'd1, 1'b0, 1'b0), "rstB_w0");
        apply(mk(1'b0, 1'b1, 1'b0, 4'h7, 16'h0000, 2'd2, 1'b0, 1'b0), "rstB_w1");
        apply(mk(1'b0, 1'b1, 1'b0, 4'h1, 16'h0000, 2'd3, 1'b0, 1'b0), "rstB_w2");
        apply(mk(1'b0, 1'b1, 1'b0, 4'h9, 16'h3719, 2'd0, 1'b1, 1'b0), "rstB_w3");
        apply(mk(1'b0, 1'b1, 1'b1, 4'h2, 16'h3719, 2'd1, 1'b0, 1'b0), "rstB_p0");
        apply(mk(1'b0, 1'b1, 1'b0, 4'h2, 16'h3719, 2'd2, 1'b0, 1'b0), "rstB_p1");
        #2 rst = 1'b1;
        #1 check_obs("async_rst_midframe", 20'h00000);
        // Reset released at the falling edge; next rising edge is operational.
        apply(mk(1'b0, 1'b1, 1'b0, 4'h4, 16'h0000, 2'd0, 1'b0, 1'b0), "post_rst_nosof");
        apply(mk(1'b0, 1'b1, 1'b1, 4'h4, 16'h0000, 2'd1, 1'b0, 1'b0), "post_rst_w0");
        apply(mk(1'b0, 1'b1, 1'b0, 4'h4, 16'h0000, 2'd2, 1'b0, 1'b0), "post_rst_w1");
        apply(mk(1'b0, 1'b1, 1'b0, 4'h4, 16'h0000, 2'd3, 1'b0, 1'b0), "post_rst_w2");
        apply(mk(1'b0, 1'b1, 1'b0, 4'h4, 16'h4444, 2'd0, 1'b1, 1'b0), "post_rst_w3");
        apply(mk(1'b0, 1'b0, 1'b0, 4'h0, 16'h4444, 2'd0, 1'b0, 1'b0), "post_rst_idle");

        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_demux4a1_capture
